// File: rtl/calc_pkg.sv
// Shared constants for the calculator controller: key codes, ALU op codes,
// the ALU's NaN result code and the controller state encoding.
package calc_pkg;
  localparam logic [3:0] KEY_EQ  = 4'd10;
  localparam logic [3:0] KEY_CLR = 4'd11;
  localparam logic [3:0] OP_ADD  = 4'd12;
  localparam logic [3:0] OP_SUB  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_DIV  = 4'd15;

  localparam logic [15:0] CALC_NAN = 16'hFBAB;

  typedef enum logic [2:0] {
    ENTER1 = 3'd0,
    ENTER2 = 3'd1,
    EXEC   = 3'd2,
    CAPT   = 3'd3,
    SHOW   = 3'd4,
    ERR    = 3'd5
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return k >= OP_ADD;
  endfunction
endpackage

// File: rtl/calc_ctrl_if.sv
// Keypad, ALU and display signals of the calculator controller.
interface calc_ctrl_if;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] alu_num1;
  logic [15:0] alu_num2;
  logic [3:0]  alu_op;
  logic        alu_exe;
  logic [15:0] alu_res;
  logic [15:0] disp;
  logic        busy;
  logic        err;

  // master = the controller, slave = keypad/ALU/display side
  modport master (input  key_code, key_valid, alu_res,
                  output alu_num1, alu_num2, alu_op, alu_exe, disp, busy, err);
  modport slave  (output key_code, key_valid, alu_res,
                  input  alu_num1, alu_num2, alu_op, alu_exe, disp, busy, err);
endinterface

// File: rtl/calc_ctrl_bcd_entry.sv
// One BCD operand: nibble shift register plus digit counter.
// Priority is clr > load > digit; digits beyond MAX_DIGITS are dropped.
module bcd_entry #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic [2:0]  load_cnt,
  input  logic        dig_en,
  input  logic [3:0]  dig,
  output logic [15:0] val,
  output logic [2:0]  cnt
);
  localparam logic [2:0] MAXC = 3'(MAX_DIGITS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= '0;
      cnt <= '0;
    end else if (clr) begin
      val <= '0;
      cnt <= '0;
    end else if (load) begin
      val <= load_val;
      cnt <= load_cnt;
    end else if (dig_en && cnt < MAXC) begin
      val <= {val[11:0], dig};
      cnt <= cnt + 3'd1;
    end
  end
endmodule

// File: rtl/calc_ctrl.sv
// Calculator keypad controller: collects two BCD operands, drives the ALU and
// the display. Define CALC_CHAIN_EN to let an op key in SHOW reuse the result.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input logic         clk,
  input logic         rst,
  calc_ctrl_if.master bus
);
  localparam logic [2:0] MAXC = 3'(MAX_DIGITS);

  state_e             st, st_n;
  logic [3:0]         op, op_n;
  logic [15:0]        result;
  logic [3:0]         k;
  logic               kdig, kop, keq, kclr;
  logic [1:0]         clr_e, load_e, dig_e;
  logic [1:0][15:0]   val, load_val;
  logic [1:0][2:0]    cnt, load_cnt;
  logic [15:0]        disp;

  assign k    = bus.key_code;
  assign kdig = bus.key_valid && is_digit(k);
  assign kop  = bus.key_valid && is_op(k);
  assign keq  = bus.key_valid && (k == KEY_EQ);
  assign kclr = bus.key_valid && (k == KEY_CLR);

  // operand 0 = num1, operand 1 = num2
  for (genvar i = 0; i < 2; i++) begin : g_opnd
    bcd_entry #(.MAX_DIGITS(MAX_DIGITS)) u_ent (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_e[i]),
      .load     (load_e[i]),
      .load_val (load_val[i]),
      .load_cnt (load_cnt[i]),
      .dig_en   (dig_e[i]),
      .dig      (k),
      .val      (val[i]),
      .cnt      (cnt[i])
    );
  end

  always_comb begin
    st_n     = st;
    op_n     = op;
    clr_e    = '0;
    load_e   = '0;
    dig_e    = '0;
    load_val = '0;
    load_cnt = '0;
    if (kclr) begin
      // clear wins in every state, including the busy ones
      clr_e = 2'b11;
      op_n  = OP_ADD;
      st_n  = ENTER1;
    end else begin
      case (st)
        ENTER1: begin
          if (kdig) dig_e[0] = 1'b1;
          else if (kop) begin
            op_n     = k;
            clr_e[1] = 1'b1;
            st_n     = ENTER2;
          end
        end
        ENTER2: begin
          if (kdig) dig_e[1] = 1'b1;
          else if (kop && cnt[1] == '0) op_n = k;
          else if (keq) st_n = EXEC;
        end
        EXEC: st_n = CAPT;
        CAPT: st_n = (bus.alu_res == CALC_NAN) ? ERR : SHOW;
        SHOW: begin
          if (kdig) begin
            load_e[0]   = 1'b1;
            load_val[0] = {12'd0, k};
            load_cnt[0] = 3'd1;
            st_n        = ENTER1;
          end
`ifdef CALC_CHAIN_EN
          else if (kop) begin
            load_e[0]   = 1'b1;
            load_val[0] = result;
            load_cnt[0] = MAXC;
            op_n        = k;
            clr_e[1]    = 1'b1;
            st_n        = ENTER2;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= ENTER1;
      op     <= OP_ADD;
      result <= '0;
    end else begin
      st <= st_n;
      op <= op_n;
      if (kclr) result <= '0;
      else if (st == CAPT) result <= bus.alu_res;
    end
  end

  always_comb begin
    disp = val[0];
    case (st)
      ENTER2:           disp = (cnt[1] != '0) ? val[1] : val[0];
      EXEC, CAPT, SHOW: disp = result;
      ERR:              disp = CALC_NAN;
      default: ;
    endcase
  end

  // exe/busy/err decode straight from the state register so rst drops them at once
  assign bus.alu_exe  = (st == EXEC);
  assign bus.busy     = (st == EXEC) || (st == CAPT);
  assign bus.err      = (st == ERR);
  assign bus.alu_num1 = val[0];
  assign bus.alu_num2 = val[1];
  assign bus.alu_op   = op;
  assign bus.disp     = disp;
endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: integer-level calculator model feeds
// expected ALU requests and settled display values to a negedge monitor.
`timescale 1ns/1ps
module tb_calc_ctrl;
  import calc_pkg::*;

  localparam int MAXD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_ctrl_if bus();
  calc_ctrl #(.MAX_DIGITS(MAXD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int from_bcd(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // decimal ALU, wraps modulo 10000; -1 stands for divide by zero
  function automatic int alu_ref(input int a, input int b, input logic [3:0] op);
    case (op)
      OP_ADD:  return (a + b) % 10000;
      OP_SUB:  return ((a - b) % 10000 + 10000) % 10000;
      OP_MUL:  return (a * b) % 10000;
      default: return (b == 0) ? -1 : a / b;
    endcase
  endfunction

  function automatic logic [15:0] alu_bcd(input logic [15:0] n1, input logic [15:0] n2,
                                          input logic [3:0] op);
    int r;
    r = alu_ref(from_bcd(n1), from_bcd(n2), op);
    return (r < 0) ? CALC_NAN : to_bcd(r);
  endfunction

  // registered ALU: answer is ready during the cycle after the execute strobe
  always @(posedge clk)
    if (bus.alu_exe) bus.alu_res <= alu_bcd(bus.alu_num1, bus.alu_num2, bus.alu_op);

  // ---------------- reference model ----------------
  typedef enum {P_A, P_B, P_RES, P_ERR} ph_e;
  typedef struct packed { logic [15:0] n1; logic [15:0] n2; logic [3:0] op; } exe_t;
  typedef struct packed { logic [15:0] disp; logic err; } out_t;

  ph_e        ph;
  int         ma, mb, na, nb, mres, busy_left;
  logic [3:0] mop;
  exe_t       exe_q[$];
  out_t       chk_q[$];

  task automatic model_reset();
    ph = P_A; ma = 0; mb = 0; na = 0; nb = 0; mres = 0; mop = OP_ADD; busy_left = 0;
  endtask

  task automatic model_key(input logic [3:0] key);
    int r;
    if (key == KEY_CLR) model_reset();
    else if (busy_left > 0 || ph == P_ERR) ;
    else if (key <= 4'd9) begin
      case (ph)
        P_A:   if (na < MAXD) begin ma = ma * 10 + int'(key); na++; end
        P_B:   if (nb < MAXD) begin mb = mb * 10 + int'(key); nb++; end
        P_RES: begin ma = int'(key); na = 1; ph = P_A; end
        default: ;
      endcase
    end else if (key >= OP_ADD) begin
      case (ph)
        P_A: begin mop = key; mb = 0; nb = 0; ph = P_B; end
        P_B: if (nb == 0) mop = key;
`ifdef CALC_CHAIN_EN
        P_RES: begin ma = mres; na = MAXD; mop = key; mb = 0; nb = 0; ph = P_B; end
`endif
        default: ;
      endcase
    end else if (key == KEY_EQ && ph == P_B) begin
      exe_q.push_back('{n1: to_bcd(ma), n2: to_bcd(mb), op: mop});
      r = alu_ref(ma, mb, mop);
      if (r < 0) ph = P_ERR;
      else begin mres = r; ph = P_RES; end
      busy_left = 3;
    end
  endtask

  function automatic logic [15:0] model_disp();
    case (ph)
      P_A:     return to_bcd(ma);
      P_B:     return (nb > 0) ? to_bcd(mb) : to_bcd(ma);
      P_RES:   return to_bcd(mres);
      default: return CALC_NAN;
    endcase
  endfunction

  // one key strobe, then 'gap' idle cycles; outputs are checked only if the gap lets them settle
  task automatic press(input logic [3:0] key, input int gap);
    model_key(key);
    if (gap >= 2) chk_q.push_back('{disp: model_disp(), err: (ph == P_ERR)});
    busy_left = (busy_left > gap + 1) ? busy_left - (gap + 1) : 0;
    bus.key_code  = key;
    bus.key_valid = 1'b1;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // ---------------- monitor ----------------
  int   since   = 3;
  logic prev_eq = 1'b0;
  logic prev_exe = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      since   = 3;
      prev_eq = 1'b0;
    end else begin
      prev_eq = bus.key_valid && bus.key_code == KEY_EQ;
      since   = bus.key_valid ? 0 : ((since < 3) ? since + 1 : 3);
    end
  end

  always @(negedge clk) begin
    exe_t e;
    out_t o;
    if (rst) prev_exe = 1'b0;
    else begin
      if (bus.alu_exe) begin
        check("exe_one_cycle_after_eq", prev_eq, 1'b1);
        check("exe_width", prev_exe, 1'b0);
        check("exe_busy", bus.busy, 1'b1);
        check("exe_expected", exe_q.size() != 0, 1'b1);
        if (exe_q.size() != 0) begin
          e = exe_q.pop_front();
          check("alu_num1", bus.alu_num1, e.n1);
          check("alu_num2", bus.alu_num2, e.n2);
          check("alu_op", bus.alu_op, e.op);
        end
      end
      prev_exe = bus.alu_exe;
      if (since == 2) begin
        check("disp_expected", chk_q.size() != 0, 1'b1);
        if (chk_q.size() != 0) begin
          o = chk_q.pop_front();
          check("disp", bus.disp, o.disp);
          check("err", bus.err, o.err);
          check("busy_idle", bus.busy, 1'b0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_num1"}, bus.alu_num1, 16'h0);
    check({tag, "_num2"}, bus.alu_num2, 16'h0);
    check({tag, "_op"},   bus.alu_op, OP_ADD);
    check({tag, "_exe"},  bus.alu_exe, 1'b0);
    check({tag, "_disp"}, bus.disp, 16'h0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_err"},  bus.err, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int r, g;
    logic [3:0] key;
    bus.key_code  = 4'd0;
    bus.key_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_released");

    // 12 + 34 = 46
    press(4'd1, 2); press(4'd2, 2); press(OP_ADD, 2);
    press(4'd3, 2); press(4'd4, 2); press(KEY_EQ, 3);
    // divide by zero -> error, digit ignored, clear recovers
    press(4'd7, 2); press(OP_DIV, 2); press(4'd0, 2); press(KEY_EQ, 3);
    press(4'd5, 2); press(KEY_CLR, 2);
    // fifth digit dropped, op replaced before num2 digits, 1234 - 2
    press(4'd1, 2); press(4'd2, 2); press(4'd3, 2); press(4'd4, 2); press(4'd5, 2);
    press(OP_MUL, 2); press(OP_SUB, 2); press(4'd2, 2); press(KEY_EQ, 3);
    // op ignored once num2 has digits; equals with no num2 digits
    press(KEY_CLR, 2); press(4'd8, 2); press(OP_MUL, 2); press(KEY_EQ, 3);
    press(KEY_CLR, 2); press(4'd6, 2); press(OP_ADD, 2); press(4'd1, 2);
    press(OP_MUL, 2); press(KEY_EQ, 3);
    // equals in ENTER1 ignored; digit in SHOW starts a new num1
    press(KEY_EQ, 2); press(4'd3, 2);
    // clear in the EXEC cycle
    press(KEY_CLR, 2); press(4'd4, 2); press(OP_ADD, 2); press(4'd5, 2);
    press(KEY_EQ, 0); press(KEY_CLR, 3);
    // keys during EXEC and CAPT ignored, then clear during CAPT
    press(4'd3, 2); press(OP_ADD, 2); press(4'd4, 2);
    press(KEY_EQ, 0); press(4'd7, 0); press(4'd8, 3);
    press(4'd2, 2); press(OP_ADD, 2); press(4'd2, 2);
    press(KEY_EQ, 1); press(KEY_CLR, 3);
    // chaining from SHOW
    press(4'd9, 2); press(OP_ADD, 2); press(4'd1, 2); press(KEY_EQ, 3);
    press(OP_ADD, 2); press(4'd5, 2); press(KEY_EQ, 3);

    // reset asserted while the execute strobe is high
    press(KEY_CLR, 2); press(4'd1, 2); press(OP_ADD, 2); press(4'd2, 2);
    bus.key_code  = KEY_EQ;
    bus.key_valid = 1'b1;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    check("exe_before_rst", bus.alu_exe, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_exec");
    exe_q.delete();
    chk_q.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // randomized key stream
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      key = 4'($urandom_range(0, 9));
      else if (r < 75) key = 4'($urandom_range(12, 15));
      else if (r < 93) key = KEY_EQ;
      else             key = KEY_CLR;
      g = ($urandom_range(0, 9) < 7) ? $urandom_range(2, 4) : $urandom_range(0, 1);
      press(key, g);
    end
    press(KEY_CLR, 3);
    repeat (6) @(posedge clk);
    #1;
    check("exe_q_drained", exe_q.size(), 0);
    check("chk_q_drained", chk_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 4, giving the maximum BCD digits accepted per operand (legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port key_code, input, 4 bits: 0-9 digit, 10 equals, 11 clear, 12 plus, 13 minus, 14 mult, 15 div.
REQ-005 The block SHALL have port key_valid, input, 1 bit: one-cycle strobe qualifying key_code.
REQ-006 The block SHALL have ports alu_num1 and alu_num2, output, 16 bits each: BCD operands to the ALU.
REQ-007 The block SHALL have port alu_op, output, 4 bits: operator code to the ALU (12..15).
REQ-008 The block SHALL have port alu_exe, output, 1 bit: registered execute strobe to the ALU.
REQ-009 The block SHALL have port alu_res, input, 16 bits: BCD result from the ALU.
REQ-010 The block SHALL have port disp, output, 16 bits: BCD value for the display.
REQ-011 The block SHALL have ports busy and err, output, 1 bit each: busy = EXEC/CAPT active; err = ERR state.

Function
REQ-012 The FSM SHALL have states ENTER1, ENTER2, EXEC, CAPT, SHOW, ERR, and reset to ENTER1.
REQ-013 A digit key SHALL shift the current operand left one nibble and insert the digit; digits beyond MAX_DIGITS SHALL be ignored.
REQ-014 In ENTER1 an op key SHALL latch alu_op, clear num2 and its digit count, and go to ENTER2; num1 SHALL be 0 if no digits were entered.
REQ-015 In ENTER2 an op key with zero num2 digits SHALL replace alu_op; an op key with num2 digits SHALL be ignored.
REQ-016 Equals in ENTER2 SHALL go to EXEC, with num2 = 0 if no digits were entered; equals in ENTER1, SHOW or ERR SHALL be ignored.
REQ-017 EXEC SHALL last exactly 1 cycle with alu_exe = 1, then go to CAPT; alu_exe SHALL be 0 in every other state.
REQ-018 alu_num1, alu_num2 and alu_op SHALL be stable from 1 cycle before alu_exe rises until CAPT ends.
REQ-019 CAPT SHALL register alu_res into the result register; it SHALL go to ERR if alu_res = 16'hFBAB, else to SHOW.
REQ-020 Latency SHALL be: equals sampled in cycle N -> alu_exe high in N+1 -> result register and disp valid in N+3.
REQ-021 key_valid SHALL be ignored while busy = 1, except clear.
REQ-022 Clear SHALL be honoured in every state, including EXEC/CAPT: zero num1, num2, result and digit counts, set alu_op = 12, go to ENTER1, and force alu_exe low on the next cycle.
REQ-023 In SHOW a digit SHALL start a new num1 (cleared, then the digit inserted) and go to ENTER1.
REQ-024 In ERR all keys except clear SHALL be ignored.
REQ-025 disp SHALL be num1 in ENTER1; num2 in ENTER2 with at least one digit, else num1; result in SHOW, EXEC and CAPT; 16'hFBAB in ERR.
REQ-026 The block SHALL pass ALU results through unchecked: no overflow or negative detection beyond the NaN code.

Reset
REQ-027 On rst: state = ENTER1; alu_num1, alu_num2, result and disp = 0; alu_op = 12; alu_exe, busy and err = 0; digit counts = 0.
REQ-028 rst SHALL act immediately and asynchronously, including mid-EXEC, so that alu_exe drops with rst.

Configuration
REQ-029 With CALC_CHAIN_EN defined, an op key in SHOW SHALL load num1 = result, latch alu_op, and go to ENTER2.
REQ-030 Without CALC_CHAIN_EN, an op key in SHOW SHALL be ignored.

Structure
REQ-031 Package calc_pkg SHALL hold the key codes, op codes 12..15, the NAN constant 16'hFBAB, and the state enum.
REQ-032 Sub-module bcd_entry SHALL implement one operand: nibble shift register plus digit counter with clear and load inputs; calc_ctrl SHALL instantiate it twice.

Verification
REQ-033 Keys 1,2,+,3,4,= -> alu_exe one-cycle pulse with num1 = 0x0012, num2 = 0x0034, op = 12; disp = 0x0046 three cycles after equals.
REQ-034 Keys 7,/,0,= -> err = 1, disp = 0xFBAB; then digit 5 ignored; then clear -> ENTER1, disp = 0, err = 0.
REQ-035 Keys 1,2,3,4,5 -> disp = 0x1234; then *,-,2,= -> op = 13, result 0x1232.
REQ-036 Clear asserted in the EXEC cycle -> alu_exe low the next cycle, state ENTER1; rst mid-EXEC -> all outputs at reset values.
REQ-037 Keys 9,+,1,= then + with CALC_CHAIN_EN -> num1 = 0x0010, state ENTER2; without the macro -> state stays SHOW.
